// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// master drives start/a/b; slave returns busy/done/sum/cout.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell and a carry flop add two
// WIDTH-bit operands LSB-first, sequenced by a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    s       = ra_q[0] ^ rb_q[0] ^ c_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        c_d   = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
        ra_d  = {1'b0, ra_q[WIDTH-1:1]};
        rb_d  = {1'b0, rb_q[WIDTH-1:1]};
        rs_d  = {s, rs_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        // Result is committed from the next-state values so the last bit and carry land together.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = rs_d;
          cout_d  = c_d;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=4
// against an arithmetic reference ({cout,sum} = a + b).
module tb_serial_adder;

  logic clk;
  logic rst;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int unsigned vectors;
  int unsigned miscompares;
  logic [7:0]  prev_sum;
  logic        prev_cout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation; with disturb set, operands change and start pulses mid-SHIFT.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit disturb);
    logic [8:0]  exp;
    int unsigned lat;
    int unsigned busy_n;
    bit          got;
    exp = {1'b0, a} + {1'b0, b};
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    tick;
    bus8.start = 1'b0;
    chk("accept_busy", bus8.busy, 1);
    busy_n = 1;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 30 && !got; i++) begin
      if (disturb && i == 3) begin
        bus8.a = 8'hAA;
        bus8.b = 8'hAA;
        bus8.start = 1'b1;
      end
      if (disturb && i == 4) bus8.start = 1'b0;
      tick;
      lat = i;
      if (bus8.done) got = 1'b1;
      else begin
        if (bus8.busy) busy_n++;
        chk("hold_result", {bus8.cout, bus8.sum}, {prev_cout, prev_sum});
      end
    end
    chk("done_seen", got, 1);
    chk("latency", lat, 8);
    chk("busy_cycles", busy_n, 8);
    chk("busy_with_done", bus8.busy, 0);
    chk("sum8", bus8.sum, exp[7:0]);
    chk("cout8", bus8.cout, exp[8]);
    prev_sum = exp[7:0];
    prev_cout = exp[8];
    tick;
    chk("done_pulse_end", bus8.done, 0);
    chk("idle_busy", bus8.busy, 0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] exp;
    bit         got;
    exp = {1'b0, a} + {1'b0, b};
    bus4.a = a;
    bus4.b = b;
    bus4.start = 1'b1;
    tick;
    bus4.start = 1'b0;
    got = 1'b0;
    for (int i = 1; i <= 12 && !got; i++) begin
      tick;
      if (bus4.done) begin
        got = 1'b1;
        chk("latency4", i, 4);
      end
    end
    chk("done4_seen", got, 1);
    chk("sum4", {bus4.cout, bus4.sum}, exp);
    tick;
  endtask

  initial begin
    logic [7:0] oa [4];
    logic [7:0] ob [4];
    logic [8:0] e;
    int unsigned perm [256];
    int unsigned j, t;

    vectors = 0;
    miscompares = 0;
    prev_sum = '0;
    prev_cout = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;

    // Reset values
    rst = 1'b1;
    #1;
    chk("rst_busy", bus8.busy, 0);
    chk("rst_done", bus8.done, 0);
    chk("rst_sum", bus8.sum, 0);
    chk("rst_cout", bus8.cout, 0);
    chk("rst_done4", bus4.done, 0);
    tick;
    rst = 1'b0;
    tick;

    // Basic add and carry chain
    run8(8'h3C, 8'h5A, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hFF, 8'hFF, 1'b0);
    run8(8'h00, 8'h00, 1'b0);

    // Operand isolation, start ignored in SHIFT
    run8(8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("no_second_op", bus8.busy, 0);
      chk("no_second_done", bus8.done, 0);
    end

    // Back-to-back with start held high: one accept every 10 cycles
    for (int k = 0; k < 4; k++) begin
      oa[k] = 8'($urandom);
      ob[k] = 8'($urandom);
    end
    bus8.a = oa[0];
    bus8.b = ob[0];
    bus8.start = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_accept", bus8.busy, 1);
      e = {1'b0, oa[k]} + {1'b0, ob[k]};
      if (k < 3) begin
        bus8.a = oa[k+1];
        bus8.b = ob[k+1];
      end else begin
        bus8.start = 1'b0;
      end
      for (int c = 1; c <= 9; c++) begin
        tick;
        if (c < 8) begin
          chk("b2b_busy", bus8.busy, 1);
          chk("b2b_hold", {bus8.cout, bus8.sum}, {prev_cout, prev_sum});
        end else if (c == 8) begin
          chk("b2b_done", bus8.done, 1);
          chk("b2b_result", {bus8.cout, bus8.sum}, e);
          prev_sum = e[7:0];
          prev_cout = e[8];
        end else begin
          chk("b2b_done_once", bus8.done, 0);
          chk("b2b_idle", bus8.busy, 0);
        end
      end
      if (k < 3) tick;
    end
    tick;

    // Randomized operands
    for (int k = 0; k < 12; k++) run8(8'($urandom), 8'($urandom), 1'b0);

    // Reset mid-operation after 4 SHIFT edges
    run8(8'hFF, 8'hFF, 1'b0);
    bus8.a = 8'hFF;
    bus8.b = 8'hFF;
    bus8.start = 1'b1;
    tick;
    bus8.start = 1'b0;
    repeat (4) tick;
    chk("pre_rst_busy", bus8.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", bus8.busy, 0);
    chk("async_rst_done", bus8.done, 0);
    chk("async_rst_sum", bus8.sum, 0);
    chk("async_rst_cout", bus8.cout, 0);
    tick;
    prev_sum = '0;
    prev_cout = 1'b0;
    rst = 1'b0;
    run8(8'h01, 8'h02, 1'b0);

    // Exhaustive 4-bit, shuffled order
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++) run4(4'(perm[i] >> 4), 4'(perm[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder: adds two WIDTH-bit operands LSB-first over WIDTH clock cycles using one full-adder cell and a carry flip-flop. It is the additive counterpart to the team's half-subtractor cell, and the first sequential arithmetic block in the library. It is intended for area-constrained datapaths where latency is acceptable. A start/busy/done handshake sequences each operation.

## Interface
- WIDTH, default 8, operand and sum width in bits (WIDTH >= 2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  single-cycle pulse when sum/cout are updated
- sum  output  WIDTH  (a + b) mod 2^WIDTH of the last completed operation
- cout  output  1  carry out of the last completed operation

## Operation
- Only one clock; reset is asynchronous and active-high.
- States:
  - IDLE: waits for start.
  - SHIFT: processes bits.
  - DONE: presents the result for one cycle.
- IDLE -> SHIFT: on an edge with start=1.
  - Load shift registers ra<=a and rb<=b; clear carry c<=0 and counter cnt<=0.
- SHIFT, each edge:
  - s = ra[0]^rb[0]^c
  - c <= ra[0]&rb[0] | ra[0]&c | rb[0]&c
  - ra and rb shift right one place.
  - Partial-sum register rs shifts right, with s inserted at the MSB.
  - cnt <= cnt+1.
- SHIFT -> DONE: on the edge where cnt==WIDTH-1. On that edge:
  - sum <= final rs, including the last bit.
  - cout <= final carry.
- DONE -> IDLE: unconditionally on the next edge.
- start is ignored in SHIFT and DONE. It is neither queued nor counted.
- a and b may change freely after the accepting edge; only the captured copies are used.
- sum and cout hold their value from completion until the next completion. They are never partially updated.
- Arithmetic is unsigned. The true result is {cout,sum} = a + b, WIDTH+1 bits.
- The counter is wide enough to hold WIDTH-1, i.e. $clog2(WIDTH) bits.

## Timing
- Reset values (asserted asynchronously, independent of clk):
  - state=IDLE
  - busy=0, done=0
  - sum=0, cout=0
  - internal ra, rb, rs, c, cnt = 0
- Edge E0 accepts start. After E0, busy=1.
- Edges E1..E(WIDTH) process bits 0..WIDTH-1.
- After E(WIDTH):
  - busy=0, done=1
  - sum and cout are valid.
- After E(WIDTH+1): done=0, state=IDLE. The earliest next accept is E(WIDTH+2).
- Start-to-done latency is WIDTH+1 edges. Throughput is one operation per WIDTH+2 cycles when start is held high.
- busy and done are registered (Moore) outputs and are never high together.
- Reset mid-operation:
  - The operation is abandoned and all outputs return to their reset values immediately.
  - After rst falls, the first edge with start=1 begins a fresh operation.
- If start=1 in the same cycle rst deasserts: the edge after deassertion accepts normally.

## Test plan
- Basic add, WIDTH=8: a=0x3C, b=0x5A, start pulse -> busy high for exactly 8 cycles; done pulse 9 edges after accept; sum=0x96, cout=0.
- Carry chain, WIDTH=8:
  - a=0xFF, b=0x01 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF -> sum=0xFE, cout=1.
  - a=0x00, b=0x00 -> sum=0x00, cout=0.
- Operand isolation and start ignored:
  - Accept a=0x12, b=0x34.
  - During SHIFT, change a/b to 0xAA/0xAA and pulse start.
  - Required: sum=0x46, cout=0; exactly one done pulse; no second operation begins.
- Back-to-back with start held at 1:
  - Operations accepted every 10 cycles.
  - sum/cout hold the previous result until each new done.
  - done is never high for two consecutive cycles.
- Reset mid-operation:
  - Assert rst after 4 SHIFT edges of a=0xFF, b=0xFF.
  - Required: busy, done, sum and cout go to 0 immediately, without waiting for a clock edge.
  - After release, a=0x01, b=0x02 gives sum=0x03, cout=0.
- Exhaustive, WIDTH=4: all 256 {a,b} pairs give {cout,sum} == a+b, with the reference model compared on each done pulse.
